// File: rtl/pixel_strip_pkg.sv
// Shared definitions for the pixel strip controller: FSM state codes,
// the packed 24-bit pixel type and the latch-gap length derivation.
package pixel_strip_pkg;

  // FSM state codes, kept as plain constants so older tools can read them
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_ISSUE     = 3'd2;
  localparam state_t ST_WAIT_ACK  = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;
  localparam state_t ST_LATCH     = 3'd5;

  // One pixel as stored in the buffer: red in the top byte, blue in the bottom
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  // Number of clock cycles the line must idle low after a frame
  function automatic int latch_cycles(input int clk_hz, input int latch_us);
    return (clk_hz / 1_000_000) * latch_us;
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port pixel buffer: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module pixel_ram
  import pixel_strip_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  pixel_t        i_wrData,
  input  logic          i_rdEn,
  input  logic [AW-1:0] i_rdAddr,
  output pixel_t        o_rdData
);

  pixel_t r_mem [DEPTH];
  pixel_t r_rdData;

  // Storage is never reset so the picture survives a controller reset;
  // out-of-range writes are dropped, and the non-blocking read gives read-first
  always_ff @(posedge clk) begin
    if (i_wrEn && (int'(i_wrAddr) < DEPTH)) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/pixel_strip_ctrl.sv
// Pixel strip refresh controller: walks the pixel buffer in index order,
// hands each pixel to an external writer with a valid/busy handshake, then
// holds a latch gap before signalling frame completion.
module pixel_strip_ctrl
  import pixel_strip_pkg::*;
#(
  parameter int NUM_PIXELS  = 8,
  parameter int CLK_HZ      = 12_000_000,
  parameter int LATCH_US    = 80,
  parameter int ACK_TIMEOUT = 64,
  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
  output logic          frame_busy,
  output logic          frame_done,
  output logic          error,
  output logic          pix_valid,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  input  logic          pix_busy
);

  localparam int            LATCH_CYCLES = latch_cycles(CLK_HZ, LATCH_US);
  localparam logic [31:0]   LATCH_LAST   = (LATCH_CYCLES > 1) ? 32'(LATCH_CYCLES - 1) : 32'd1;
  localparam logic [31:0]   ACK_LAST     = (ACK_TIMEOUT > 1) ? 32'(ACK_TIMEOUT - 1) : 32'd0;
  localparam logic [AW-1:0] LAST_INDEX   = AW'(NUM_PIXELS - 1);

  state_t        r_state;
  logic [AW-1:0] r_index;
  logic [31:0]   r_latchCnt;
  logic [31:0]   r_ackCnt;
  logic          r_frameBusy;
  logic          r_frameDone;
  logic          r_error;
  logic          r_pixValid;
  logic [7:0]    r_pixR;
  logic [7:0]    r_pixG;
  logic [7:0]    r_pixB;

  pixel_t        w_rdData;
  logic          w_rdEn;

  assign w_rdEn = (r_state == ST_FETCH);

  pixel_ram #(
    .DEPTH (NUM_PIXELS),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (wr_en),
    .i_wrAddr (wr_addr),
    .i_wrData (wr_data),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (r_index),
    .o_rdData (w_rdData)
  );

  // Frame sequencer: state, pixel index, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_latchCnt  <= '0;
      r_ackCnt    <= '0;
      r_frameBusy <= 1'b0;
      r_frameDone <= 1'b0;
      r_error     <= 1'b0;
      r_pixValid  <= 1'b0;
      r_pixR      <= '0;
      r_pixG      <= '0;
      r_pixB      <= '0;
    end else begin
      r_frameDone <= 1'b0;
      r_pixValid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_FETCH;
            r_index     <= '0;
            r_error     <= 1'b0;
            r_frameBusy <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_pixR     <= w_rdData.red;
          r_pixG     <= w_rdData.green;
          r_pixB     <= w_rdData.blue;
          r_pixValid <= 1'b1;
          r_ackCnt   <= '0;
          r_state    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (pix_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_ackCnt >= ACK_LAST) begin
            r_error     <= 1'b1;
            r_state     <= ST_IDLE;
            r_frameBusy <= 1'b0;
          end else begin
            r_ackCnt <= r_ackCnt + 32'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!pix_busy) begin
            if (r_index == LAST_INDEX) begin
              // The cycle in which busy fell is already the first idle-low
              // cycle of the gap, so the count starts at one
              r_latchCnt <= 32'd1;
              r_state    <= ST_LATCH;
            end else begin
              r_index <= r_index + AW'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_LATCH: begin
          if (r_latchCnt >= LATCH_LAST) begin
            r_latchCnt  <= '0;
            r_frameDone <= 1'b1;
            r_frameBusy <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_latchCnt <= r_latchCnt + 32'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_frameBusy <= 1'b0;
        end
      endcase
    end
  end

  assign frame_busy = r_frameBusy;
  assign frame_done = r_frameDone;
  assign error      = r_error;
  assign pix_valid  = r_pixValid;
  assign pix_r      = r_pixR;
  assign pix_g      = r_pixG;
  assign pix_b      = r_pixB;

endmodule

// File: doc/pixel_strip_ctrl.md
PIXEL_STRIP_CTRL -- requirements
Module: pixel_strip_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 8, number of pixels in the strip (1..256).
REQ-002 Parameter CLK_HZ, default 12_000_000, input clock frequency.
REQ-003 Parameter LATCH_US, default 80, idle-low latch gap after each frame, in microseconds.
REQ-004 Parameter ACK_TIMEOUT, default 64, maximum cycles from pix_valid to pix_busy high.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 wr_en  input  1  pixel buffer write strobe.
REQ-009 wr_addr  input  AW=max(1,clog2(NUM_PIXELS))  pixel index to write.
REQ-010 wr_data  input  24  pixel colour, [23:16]=red, [15:8]=green, [7:0]=blue.
REQ-011 start  input  1  request one frame refresh.
REQ-012 frame_busy  output  1  high while a frame is in progress.
REQ-013 frame_done  output  1  one-cycle pulse on successful frame completion.
REQ-014 error  output  1  sticky ack-timeout flag.
REQ-015 pix_valid  output  1  one-cycle strobe to the pixel writer.
REQ-016 pix_r, pix_g, pix_b  output  8 each  colour presented with pix_valid.
REQ-017 pix_busy  input  1  pixel writer busy.

Function
REQ-018 The block SHALL hold a NUM_PIXELS x 24 buffer with a synchronous write on wr_en; writes with wr_addr >= NUM_PIXELS SHALL be ignored.
REQ-019 Buffer reads SHALL be synchronous with 1-cycle latency and read-first on same-address collision.
REQ-020 Writes SHALL be accepted in every state, including mid-frame.
REQ-021 The FSM states SHALL be IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, LATCH.
REQ-022 IDLE->FETCH on start; the pixel index SHALL clear to 0; start SHALL be ignored outside IDLE.
REQ-023 FETCH presents the pixel index to the buffer, then ->ISSUE.
REQ-024 ISSUE drives pix_r/g/b from the buffer and asserts pix_valid for exactly one cycle, then ->WAIT_ACK.
REQ-025 pix_r/g/b SHALL hold their value until the next ISSUE.
REQ-026 WAIT_ACK->WAIT_DONE when pix_busy=1.
REQ-027 In WAIT_ACK, if pix_busy stays 0 for ACK_TIMEOUT cycles after pix_valid, the FSM SHALL set error=1 and go ->IDLE with no frame_done pulse.
REQ-028 WAIT_DONE, on pix_busy=0: index<NUM_PIXELS-1 -> increment index, ->FETCH; else ->LATCH.
REQ-029 LATCH SHALL count LATCH_CYCLES=CLK_HZ/1_000_000*LATCH_US cycles, then pulse frame_done for one cycle and go ->IDLE.
REQ-030 frame_busy SHALL be 1 in every state except IDLE, registered, and updated in the same cycle as the state register.
REQ-031 error SHALL clear on an accepted start and SHALL otherwise hold.
REQ-032 If start and wr_en address pixel 0 in the same cycle, the frame SHALL transmit the newly written value.
REQ-033 Pixels SHALL be sent in index order 0..NUM_PIXELS-1 with no skipped or repeated index.

Reset
REQ-034 While rst=1: state=IDLE, index=0, latch and timeout counters=0, pix_valid=0, pix_r/g/b=0, frame_busy=0, frame_done=0, error=0.
REQ-035 Reset mid-frame SHALL abort immediately with no frame_done; buffer contents SHALL NOT be reset and SHALL be retained.

Structure
REQ-036 The shared package pixel_strip_pkg SHALL hold the state enumeration, the 24-bit pixel type with its field slices, and the LATCH_CYCLES derivation.
REQ-037 The buffer SHALL be the sub-module pixel_ram: simple dual-port, synchronous read, read-first.

Verification
REQ-038 NUM_PIXELS=3; write 0x112233, 0x445566, 0x778899; start; writer model busy 2 cycles after valid for 20 cycles -> three pix_valid pulses with r/g/b matching in order; frame_done exactly LATCH_CYCLES=960 cycles after the last busy fall.
REQ-039 Writer model never raises busy -> error=1 exactly 64 cycles after the first pix_valid; no frame_done; frame_busy=0 the next cycle; a new start clears error.
REQ-040 Second start pulses during a frame -> ignored; exactly NUM_PIXELS valids; one frame_done.
REQ-041 Same cycle as start, write pixel 0=0xFF0000 -> first pix_r=0xFF, pix_g=0, pix_b=0; writing pixel 2 while pixel 0 is in flight -> pixel 2 carries the new value.
REQ-042 Assert rst during WAIT_DONE of pixel 1 -> all outputs at reset values the next cycle; a fresh start resends pixel 0 with the retained buffer data.
REQ-043 Write wr_addr=NUM_PIXELS (out of range) -> buffer unchanged; the next frame carries the previous data.
